// File: rtl/aes_round_sequencer.sv
// Control sequencer for a byte-serial AES-128 encryption datapath: loads a block,
// steps the round/byte counters through the key schedule, then drains the ciphertext.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS  = 10,
  parameter int BLOCK_BYTES = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic       i_sr_ready,
  input  logic       i_out_ready,
  output logic       o_out_valid,
  output logic       o_out_last,
  output logic       o_dp_enable,
  output logic       o_sb_en,
  output logic       o_mc_en,
  output logic       o_ark_en,
  output logic       o_load_sel,
  output logic [3:0] o_key_round,
  output logic [3:0] o_key_byte_idx,
  output logic [3:0] o_round_num,
  output logic       o_busy,
  output logic       o_done
);

  localparam logic [3:0] LAST_BYTE  = 4'(BLOCK_BYTES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_byte_idx;
  logic [3:0] w_byte_idx_nxt;
  logic [3:0] r_round_num;
  logic [3:0] w_round_num_nxt;
  logic       r_done;
  logic       w_done_nxt;

  // State, counter and done-pulse registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_byte_idx  <= 4'd0;
      r_round_num <= 4'd0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_round_num <= w_round_num_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state, counter advance and stage-enable decode
  always_comb begin
    w_state_nxt     = r_state;
    w_byte_idx_nxt  = r_byte_idx;
    w_round_num_nxt = r_round_num;
    w_done_nxt      = 1'b0;
    o_in_ready      = 1'b0;
    o_out_valid     = 1'b0;
    o_out_last      = 1'b0;
    o_dp_enable     = 1'b0;
    o_sb_en         = 1'b0;
    o_mc_en         = 1'b0;
    o_ark_en        = 1'b0;
    o_load_sel      = 1'b0;
    o_key_round     = 4'd0;
    o_key_byte_idx  = 4'd0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt     = S_LOAD;
          w_byte_idx_nxt  = 4'd0;
          w_round_num_nxt = 4'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_LOAD: begin
        o_in_ready     = 1'b1;
        o_load_sel     = 1'b1;
        o_ark_en       = 1'b1;
        o_dp_enable    = i_in_valid;
        o_key_byte_idx = r_byte_idx;
        if (i_in_valid) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_byte_idx_nxt  = 4'd0;
            w_round_num_nxt = 4'd1;
            w_state_nxt     = S_ROUND;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 4'd1;
          end
        end else begin
          w_byte_idx_nxt = r_byte_idx;
        end
      end

      S_ROUND: begin
        o_dp_enable    = 1'b1;
        o_sb_en        = 1'b1;
        o_ark_en       = 1'b1;
        o_mc_en        = (r_round_num < LAST_ROUND);
        o_key_round    = r_round_num;
        o_key_byte_idx = r_byte_idx;
        // Without sr_ready the shiftrows pipe is still filling, so nothing advances
        if (i_sr_ready) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_byte_idx_nxt = 4'd0;
            if (r_round_num == LAST_ROUND) begin
              w_state_nxt = S_OUT;
            end else begin
              w_round_num_nxt = r_round_num + 4'd1;
            end
          end else begin
            w_byte_idx_nxt = r_byte_idx + 4'd1;
          end
        end else begin
          w_byte_idx_nxt = r_byte_idx;
        end
      end

      S_OUT: begin
        o_out_valid = 1'b1;
        o_out_last  = (r_byte_idx == LAST_BYTE);
        o_dp_enable = i_out_ready;
        if (i_out_ready) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_state_nxt     = S_IDLE;
            w_byte_idx_nxt  = 4'd0;
            w_round_num_nxt = 4'd0;
            w_done_nxt      = 1'b1;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 4'd1;
          end
        end else begin
          w_byte_idx_nxt = r_byte_idx;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_byte_idx_nxt  = 4'd0;
        w_round_num_nxt = 4'd0;
      end
    endcase
  end

  assign o_round_num = r_round_num;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a linear-count control model checked every cycle,
// plus a behavioural AES datapath driven by the sequencer to reproduce the FIPS-197 vector.
module tb_aes_round_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, sr_ready, out_ready;
  logic       w_in_ready, w_out_valid, w_out_last, w_dp_enable;
  logic       w_sb_en, w_mc_en, w_ark_en, w_load_sel, w_busy, w_done;
  logic [3:0] w_key_round, w_key_byte_idx, w_round_num;

  aes_round_sequencer #(.NUM_ROUNDS(10), .BLOCK_BYTES(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(w_in_ready), .i_sr_ready(sr_ready), .i_out_ready(out_ready),
    .o_out_valid(w_out_valid), .o_out_last(w_out_last), .o_dp_enable(w_dp_enable),
    .o_sb_en(w_sb_en), .o_mc_en(w_mc_en), .o_ark_en(w_ark_en), .o_load_sel(w_load_sel),
    .o_key_round(w_key_round), .o_key_byte_idx(w_key_byte_idx), .o_round_num(w_round_num),
    .o_busy(w_busy), .o_done(w_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- AES reference pieces ----------------
  logic [7:0] sbox [0:255];
  logic [7:0] kb   [0:175];
  logic [7:0] rk   [0:10][0:15];
  logic [7:0] pt   [0:15];
  logic [7:0] ct_exp [0:15];
  logic [7:0] st [0:15], tmpa [0:15], nx [0:15], ct [0:15];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, rc;
    logic [7:0] t [0:3];
    logic [127:0] ctv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int i = 0; i < 16; i++) begin
      kb[i] = 8'(i);
      pt[i] = 8'(i * 17);
    end
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = kb[i - 4 + j];
      if (i % 16 == 0) begin
        t[0] = sbox[kb[i - 3]] ^ rc;
        t[1] = sbox[kb[i - 2]];
        t[2] = sbox[kb[i - 1]];
        t[3] = sbox[kb[i - 4]];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) kb[i + j] = kb[i - 16 + j] ^ t[j];
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 16; j++) rk[r][j] = kb[16 * r + j];
    ctv = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int i = 0; i < 16; i++) ct_exp[i] = ctv[127 - 8 * i -: 8];
  endtask

  // SubBytes (optional), ShiftRows, MixColumns (optional) into tmpa
  task automatic round_xform(input logic sbf, input logic mcf);
    logic [7:0] a [0:15], b [0:15];
    logic [7:0] s0, s1, s2, s3;
    for (int i = 0; i < 16; i++) a[i] = sbf ? sbox[st[i]] : st[i];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r + 4 * c] = a[r + 4 * ((c + r) % 4)];
    for (int c = 0; c < 4; c++) begin
      s0 = b[4 * c]; s1 = b[4 * c + 1]; s2 = b[4 * c + 2]; s3 = b[4 * c + 3];
      if (mcf) begin
        tmpa[4 * c]     = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
        tmpa[4 * c + 1] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
        tmpa[4 * c + 2] = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
        tmpa[4 * c + 3] = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
      end else begin
        tmpa[4 * c] = s0; tmpa[4 * c + 1] = s1; tmpa[4 * c + 2] = s2; tmpa[4 * c + 3] = s3;
      end
    end
  endtask

  // ---------------- sequencer model: phase + linear advance count ----------------
  localparam int P_IDLE = 0, P_LOAD = 1, P_ROUND = 2, P_OUT = 3;
  int   ph = P_IDLE, cnt = 0, rel = 0;
  logic m_done = 1'b0;
  logic chk_en = 1'b0;
  int   hc = 0, oc = 0, done_seen = 0, done_rel = -1;
  logic lit_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph = P_IDLE; cnt = 0; m_done = 1'b0; chk_en = 1'b1;
    end else begin
      m_done = (ph == P_OUT) && out_ready && (cnt == 15);
      case (ph)
        P_IDLE:  if (start) begin ph = P_LOAD; cnt = 0; rel = 0; end
        P_LOAD:  if (in_valid) begin cnt++; if (cnt == 16) begin ph = P_ROUND; cnt = 0; end end
        P_ROUND: if (sr_ready) begin cnt++; if (cnt == 160) begin ph = P_OUT; cnt = 0; end end
        P_OUT:   if (out_ready) begin cnt++; if (cnt == 16) begin ph = P_IDLE; cnt = 0; end end
        default: ph = P_IDLE;
      endcase
    end
    rel++;
  end

  // compare DUT against the model and run the behavioural datapath
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  w_in_ready,  ph == P_LOAD);
      chk("load_sel",  w_load_sel,  ph == P_LOAD);
      chk("ark_en",    w_ark_en,    ph == P_LOAD || ph == P_ROUND);
      chk("sb_en",     w_sb_en,     ph == P_ROUND);
      chk("mc_en",     w_mc_en,     ph == P_ROUND && (cnt / 16) < 9);
      chk("out_valid", w_out_valid, ph == P_OUT);
      chk("out_last",  w_out_last,  ph == P_OUT && cnt == 15);
      chk("dp_enable", w_dp_enable, (ph == P_LOAD && in_valid) || ph == P_ROUND || (ph == P_OUT && out_ready));
      chk("busy",      w_busy,      ph != P_IDLE);
      chk("done",      w_done,      m_done);
      chk("round_num", w_round_num, ph == P_ROUND ? cnt / 16 + 1 : (ph == P_OUT ? 10 : 0));
      chk("key_round", w_key_round, ph == P_ROUND ? cnt / 16 + 1 : 0);
      chk("key_byte_idx", w_key_byte_idx, (ph == P_LOAD || ph == P_ROUND) ? cnt % 16 : 0);
      if (lit_en) begin
        if (rel == 1)   chk("nom_in_ready_c1", w_in_ready, 1);
        if (rel == 16)  chk("nom_in_ready_c16", w_in_ready, 1);
        if (rel == 17)  chk("nom_in_ready_c17", w_in_ready, 0);
        if (rel == 17)  chk("nom_round1_c17", w_round_num, 1);
        if (rel == 160) chk("nom_mc_c160", w_mc_en, 1);
        if (rel == 161) chk("nom_mc_c161", w_mc_en, 0);
        if (rel == 176) chk("nom_round10_c176", w_round_num, 10);
        if (rel == 192) chk("nom_out_last_c192", w_out_last, 1);
      end
      if (w_done === 1'b1) begin done_seen++; done_rel = rel; end
      if (!rst) begin
        if (w_load_sel && w_dp_enable) begin
          st[w_key_byte_idx] = pt[hc & 15] ^ rk[0][w_key_byte_idx];
          hc++;
        end
        if (w_sb_en && w_dp_enable && sr_ready && w_key_round <= 4'd10) begin
          if (w_key_byte_idx == 4'd0) round_xform(w_sb_en, w_mc_en);
          nx[w_key_byte_idx] = tmpa[w_key_byte_idx] ^ (w_ark_en ? rk[w_key_round][w_key_byte_idx] : 8'h00);
          if (w_key_byte_idx == 4'd15) for (int i = 0; i < 16; i++) st[i] = nx[i];
        end
        if (w_out_valid && out_ready) begin
          ct[oc & 15] = st[oc & 15];
          oc++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input string nm, input logic tog_in, input logic out_stall,
                           input logic fill, input logic glitch, input int exp_rel, input int abort_at);
    int   n = 0, stalls = 0, rc = 0, ost = 0, d0;
    logic tog = 1'b1;
    d0 = done_seen;
    hc = 0; oc = 0;
    for (int i = 0; i < 16; i++) ct[i] = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    while (ph != P_IDLE && n < 1000) begin
      in_valid = 1'b0; sr_ready = 1'b1; out_ready = 1'b1; start = 1'b0;
      case (ph)
        P_LOAD: begin
          in_valid = tog_in ? tog : 1'b1;
          tog = ~tog;
          if (glitch && cnt == 3) start = 1'b1;
        end
        P_ROUND: begin
          if (fill && rc < 11) sr_ready = 1'b0;
          rc++;
          if (abort_at >= 0 && cnt == abort_at) rst = 1'b1;
        end
        P_OUT: begin
          if (out_stall && cnt == 7 && ost < 3) begin out_ready = 1'b0; ost++; end
          if (glitch && cnt == 2) start = 1'b1;
        end
        default: ;
      endcase
      if ((ph == P_LOAD && !in_valid) || (ph == P_ROUND && !sr_ready) || (ph == P_OUT && !out_ready))
        stalls++;
      step();
      rst = 1'b0;
      n++;
    end
    in_valid = 1'b0; sr_ready = 1'b1; out_ready = 1'b1; start = 1'b0;
    chk({nm, "_timeout"}, n < 1000, 1);
    @(negedge clk);
    #1;
    if (abort_at >= 0) begin
      chk({nm, "_busy_after_reset"}, w_busy, 0);
      chk({nm, "_round_after_reset"}, w_round_num, 0);
      repeat (5) step();
      chk({nm, "_no_done"}, done_seen, d0);
    end else begin
      chk({nm, "_done_count"}, done_seen, d0 + 1);
      chk({nm, "_done_latency"}, done_rel, exp_rel);
      chk({nm, "_stall_latency"}, done_rel, 193 + stalls);
      for (int i = 0; i < 16; i++) chk({nm, "_ciphertext"}, ct[i], ct_exp[i]);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; sr_ready = 1'b1; out_ready = 1'b1;
    build_tables();
    chk("model_sbox_00", sbox[0], 8'h63);
    chk("model_sbox_53", sbox[8'h53], 8'hed);
    chk("model_rk10_b0", rk[10][0], 8'h13);
    chk("model_rk10_b15", rk[10][15], 8'hc5);
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_busy", w_busy, 0);
    chk("reset_round", w_round_num, 0);
    chk("reset_done", w_done, 0);

    // in_valid while idle must not be accepted
    in_valid = 1'b1;
    repeat (4) step();
    chk("idle_in_ready", w_in_ready, 0);
    chk("idle_key_byte_idx", w_key_byte_idx, 0);
    in_valid = 1'b0;
    step();

    lit_en = 1'b1;
    run_block("nominal", 1'b0, 1'b0, 1'b0, 1'b0, 193, -1);
    lit_en = 1'b0;
    run_block("backpressure", 1'b1, 1'b1, 1'b0, 1'b0, 211, -1);
    run_block("fill_stall", 1'b0, 1'b0, 1'b1, 1'b0, 204, -1);
    run_block("abort", 1'b0, 1'b0, 1'b0, 1'b0, 0, 73);
    run_block("after_abort", 1'b0, 1'b0, 1'b0, 1'b0, 193, -1);
    run_block("start_glitch", 1'b0, 1'b0, 1'b0, 1'b1, 193, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM for the byte-serial AES-128 encryption datapath: the sub-bytes, shiftrows, mixcolumns and add-round-key stages.
- Accepts a 16-byte plaintext block over a valid/ready handshake and drives the per-byte stage enables.
- Counts bytes and rounds, addresses the round-key store, and bypasses mixcolumns in the final round.
- Releases the 16 ciphertext bytes over a valid/ready handshake.
- Sits between the host byte interface and the datapath; contains no datapath registers itself.

Parameters:
- NUM_ROUNDS, 10, number of full rounds after the initial key add (AES-128).
- BLOCK_BYTES, 16, bytes per state block; must be a power of two.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a block; ignored unless state is IDLE.
- in_valid  input  1  host plaintext byte valid.
- in_ready  output  1  sequencer accepts a plaintext byte this cycle.
- sr_ready  input  1  shiftrows pipeline primed; byte advance in ROUND is qualified by it.
- out_ready  input  1  downstream accepts a ciphertext byte.
- out_valid  output  1  ciphertext byte valid on the datapath output.
- out_last  output  1  marks the 16th ciphertext byte.
- dp_enable  output  1  datapath shift enable for this cycle.
- sb_en  output  1  sub-bytes stage active.
- mc_en  output  1  mixcolumns active; 0 selects bypass.
- ark_en  output  1  add-round-key active.
- load_sel  output  1  1 selects host input into the datapath; 0 selects the feedback path.
- key_round  output  4  round index for the key store.
- key_byte_idx  output  4  byte index within the round key.
- round_num  output  4  current round, for debug.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last ciphertext byte is accepted.

Behaviour:
- Reset: on the clock edge where reset=1, state goes to IDLE. All outputs and counters are 0: byte_idx=0, round_num=0, done=0.
- Reset mid-block: aborts immediately; no done pulse is issued.
- States: IDLE, LOAD, ROUND, OUT.
- IDLE: all enables 0. start=1 moves to LOAD next cycle.
- LOAD, outputs:
  - in_ready=1, load_sel=1, ark_en=1.
  - sb_en=0, mc_en=0.
  - key_round=0, key_byte_idx=byte_idx.
- LOAD, per byte: dp_enable=in_valid. On each in_valid&in_ready, byte_idx increments.
- LOAD, exit: when the byte with byte_idx=15 is accepted, byte_idx wraps to 0, round_num becomes 1, and state moves to ROUND.
- ROUND, outputs:
  - dp_enable=1 and load_sel=0.
  - sb_en=1, ark_en=1.
  - mc_en=1 when round_num<NUM_ROUNDS, 0 when round_num==NUM_ROUNDS.
  - key_round=round_num, key_byte_idx=byte_idx.
- ROUND, per cycle:
  - byte_idx advances only when sr_ready=1; when sr_ready=0 the sequencer holds (fill stall).
  - On an advance from byte 15, byte_idx wraps to 0 and round_num increments.
  - At round_num==NUM_ROUNDS, byte 15, the state moves to OUT with byte_idx=0.
- OUT:
  - out_valid=1, and out_last=1 when byte_idx=15.
  - dp_enable=out_ready; all other enables 0.
  - byte_idx advances on out_valid&out_ready.
  - The handshake on byte 15 returns the state to IDLE and asserts done for exactly the next cycle (in IDLE).
- start while busy is ignored. in_valid outside LOAD is ignored, with in_ready=0.
- Counter widths: byte_idx is 4 bits and round_num is 4 bits; both wrap modulo their width, and wrap only where stated above.
- Latency with sr_ready=1, in_valid=1 and out_ready=1 throughout: start to first in_ready is 1 cycle; LOAD takes 16, ROUND takes 160 and OUT takes 16 cycles. done asserts 193 cycles after start.

Test Plan:
- Nominal block, all handshakes tied high: start at cycle 0. Required:
  - in_ready high on cycles 1-16.
  - round_num steps 1..10 every 16 cycles.
  - mc_en=0 only during round 10.
  - out_last on cycle 192, done on cycle 193.
- FIPS-197 vector: with datapath and key store attached, plaintext 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f. Required ciphertext: 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: in_valid toggles 1,0 during LOAD and out_ready low for 3 cycles at byte 7 of OUT. Required:
  - byte_idx and key_byte_idx hold while stalled.
  - out_valid stays high and the ciphertext is unchanged.
  - done is delayed by exactly the stall count.
- Fill stall: sr_ready=0 for the first 11 cycles of ROUND. Required: round_num=1 and byte_idx=0 held throughout, then a normal 160-advance sequence.
- Reset mid-ROUND (round 5, byte 9): reset one cycle. Required:
  - Next cycle busy=0, round_num=0 and all enables 0.
  - No done pulse.
  - A subsequent start completes normally.
- start pulses during LOAD and OUT: required to be ignored. in_valid in IDLE: in_ready stays 0 and byte_idx stays 0.
